mem_read_arbiter: RTL and testbench

Shares one pipelined, in-order memory read port between the instruction fetch stage and the load unit. Fixed load priority with a fetch starvation guard; requests are tagged in an outstanding-owner FIFO so returning data is routed back to the correct requester. On a fetch redirect (branch mispredict), responses for in-flight fetches are discarded without stalling the memory port.

---
 rtl/mem_read_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_read_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_read_arbiter.sv
// Arbitrates one in-order memory read port between instruction fetch and loads,
// tagging each accepted read so responses return to their requester.
module mem_read_arbiter #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_addr,
    input  logic        if_avalid,
    output logic        if_aready,
    input  logic        if_flush,
    output logic        if_valid,
    output logic [31:0] if_data,
    input  logic [31:0] ld_addr,
    input  logic        ld_avalid,
    output logic        ld_aready,
    output logic        ld_valid,
    output logic [31:0] ld_data,
    output logic [31:0] mem_addr,
    output logic        mem_avalid,
    input  logic        mem_aready,
    input  logic        mem_valid,
    input  logic [31:0] mem_data,
    output logic        busy,
    output logic        err
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned ST_W  = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_FETCH,
        GNT_LOAD
    } gnt_e;

    gnt_e             gnt;
    logic             accept;
    logic             pop;
    logic             head_is_load;
    logic             head_drop;

    // Owner bit per slot: 1 = load, 0 = fetch.
    logic [DEPTH-1:0] owner_q, owner_d;
    logic [DEPTH-1:0] drop_q,  drop_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [ST_W-1:0]  starve_q, starve_d;
    logic             err_q, err_d;

    // Request side: grant, memory handshake and per-port ready.
    always_comb begin
        gnt        = GNT_NONE;
        mem_avalid = 1'b0;
        mem_addr   = 32'h0;
        if (starve_q == ST_W'(STARVE_LIMIT) && if_avalid) begin
            gnt = GNT_FETCH;
        end else if (ld_avalid) begin
            gnt = GNT_LOAD;
        end else if (if_avalid) begin
            gnt = GNT_FETCH;
        end
        if (gnt == GNT_FETCH) begin
            mem_addr   = if_addr;
            mem_avalid = (count_q < CNT_W'(DEPTH));
        end else if (gnt == GNT_LOAD) begin
            mem_addr   = ld_addr;
            mem_avalid = (count_q < CNT_W'(DEPTH));
        end
        accept    = mem_avalid && mem_aready;
        if_aready = accept && (gnt == GNT_FETCH);
        ld_aready = accept && (gnt == GNT_LOAD);
    end

    // Response side: route the head tag; a flush also squashes a fetch head popping now.
    always_comb begin
        pop          = mem_valid && (count_q != '0);
        head_is_load = owner_q[rd_ptr_q];
        head_drop    = drop_q[rd_ptr_q];
        if_valid     = pop && !head_is_load && !head_drop && !if_flush;
        ld_valid     = pop && head_is_load && !head_drop;
        if_data      = mem_data;
        ld_data      = mem_data;
        busy         = (count_q != '0);
        err          = err_q;
    end

    always_comb begin
        owner_d  = owner_q;
        drop_d   = drop_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        starve_d = starve_q;
        err_d    = err_q;

        // Flush marks fetch slots before the push so a same-cycle fetch survives.
        if (if_flush) begin
            drop_d = drop_q | ~owner_q;
        end
        if (accept) begin
            owner_d[wr_ptr_q] = (gnt == GNT_LOAD);
            drop_d[wr_ptr_q]  = 1'b0;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (accept && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!accept && pop) begin
            count_d = count_q - CNT_W'(1);
        end

        if (mem_valid && (count_q == '0)) begin
            err_d = 1'b1;
        end

        if (if_flush || !if_avalid || if_aready) begin
            starve_d = '0;
        end else if (starve_q != ST_W'(STARVE_LIMIT)) begin
            starve_d = starve_q + ST_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q  <= '0;
            drop_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            err_q    <= 1'b0;
        end else begin
            owner_q  <= owner_d;
            drop_q   <= drop_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed bench for mem_read_arbiter with DEPTH=4, STARVE_LIMIT=8.
module tb_mem_read_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_addr;
    logic        if_avalid;
    logic        if_aready;
    logic        if_flush;
    logic        if_valid;
    logic [31:0] if_data;
    logic [31:0] ld_addr;
    logic        ld_avalid;
    logic        ld_aready;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic [31:0] mem_addr;
    logic        mem_avalid;
    logic        mem_aready;
    logic        mem_valid;
    logic [31:0] mem_data;
    logic        busy;
    logic        err;

    int tests = 0;
    int fails = 0;

    mem_read_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_addr    (if_addr),
        .if_avalid  (if_avalid),
        .if_aready  (if_aready),
        .if_flush   (if_flush),
        .if_valid   (if_valid),
        .if_data    (if_data),
        .ld_addr    (ld_addr),
        .ld_avalid  (ld_avalid),
        .ld_aready  (ld_aready),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .mem_addr   (mem_addr),
        .mem_avalid (mem_avalid),
        .mem_aready (mem_aready),
        .mem_valid  (mem_valid),
        .mem_data   (mem_data),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; if_addr = '0; if_avalid = 0; if_flush = 0;
        ld_addr = '0; ld_avalid = 0; mem_aready = 0; mem_valid = 0; mem_data = '0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_mem_avalid", mem_avalid, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_readys", {if_aready, ld_aready}, 0);
        chk("rst_valids", {if_valid, ld_valid}, 0);
        next(); next();
        rst = 1'b0;

        // Lone fetch with a one-cycle memory
        next();
        if_addr = 32'h100; if_avalid = 1; mem_aready = 1;
        #1;
        chk("f1_mem_addr", mem_addr, 32'h100);
        chk("f1_mem_avalid", mem_avalid, 1);
        chk("f1_if_aready", if_aready, 1);
        chk("f1_ld_aready", ld_aready, 0);
        next();
        if_avalid = 0; mem_valid = 1; mem_data = 32'hDEAD0100;
        #1;
        chk("f1_if_valid", if_valid, 1);
        chk("f1_if_data", if_data, 32'hDEAD0100);
        chk("f1_ld_valid", ld_valid, 0);
        chk("f1_busy", busy, 1);
        next();
        mem_valid = 0;
        #1;
        chk("f1_idle_busy", busy, 0);

        // Simultaneous load and fetch: load first
        next();
        ld_addr = 32'h2000; ld_avalid = 1; if_addr = 32'h40; if_avalid = 1;
        #1;
        chk("sim_mem_addr_ld", mem_addr, 32'h2000);
        chk("sim_ld_aready", ld_aready, 1);
        chk("sim_if_aready0", if_aready, 0);
        next();
        ld_avalid = 0; mem_valid = 1; mem_data = 32'hAAAA2000;
        #1;
        chk("sim_mem_addr_if", mem_addr, 32'h40);
        chk("sim_if_aready1", if_aready, 1);
        chk("sim_ld_valid", ld_valid, 1);
        chk("sim_ld_data", ld_data, 32'hAAAA2000);
        chk("sim_if_valid0", if_valid, 0);
        next();
        if_avalid = 0; mem_data = 32'hBBBB0040;
        #1;
        chk("sim_if_valid1", if_valid, 1);
        chk("sim_if_data", if_data, 32'hBBBB0040);
        chk("sim_ld_valid0", ld_valid, 0);
        next();
        mem_valid = 0;

        // Starvation guard: continuous loads, fetch wins on cycle 9
        if_addr = 32'h500; if_avalid = 1; ld_avalid = 1;
        for (int i = 1; i <= 8; i++) begin
            ld_addr = 32'h3000 + 32'(i);
            mem_valid = (i > 1); mem_data = 32'(i);
            #1;
            chk($sformatf("stv_ld_aready_%0d", i), ld_aready, 1);
            chk($sformatf("stv_if_aready_%0d", i), if_aready, 0);
            next();
        end
        mem_valid = 1; mem_data = 32'h8;
        #1;
        chk("stv_c9_if_aready", if_aready, 1);
        chk("stv_c9_ld_aready", ld_aready, 0);
        chk("stv_c9_mem_addr", mem_addr, 32'h500);
        chk("stv_c9_ld_valid", ld_valid, 1);
        next();
        mem_data = 32'h9;
        #1;
        chk("stv_c10_ld_aready", ld_aready, 1);
        chk("stv_c10_if_aready", if_aready, 0);
        chk("stv_c10_if_valid", if_valid, 1);
        next();
        if_avalid = 0; ld_avalid = 0; mem_data = 32'hA;
        #1;
        chk("stv_c11_ld_valid", ld_valid, 1);
        next();
        mem_valid = 0;
        #1;
        chk("stv_busy", busy, 0);

        // Flush: fetch, fetch, load outstanding; flush cycle pops the first fetch
        next();
        if_addr = 32'h10; if_avalid = 1;
        next();
        if_addr = 32'h14;
        next();
        if_avalid = 0; ld_addr = 32'h5000; ld_avalid = 1;
        next();
        ld_avalid = 0; if_flush = 1; if_addr = 32'h80; if_avalid = 1;
        mem_valid = 1; mem_data = 32'h11110010;
        #1;
        chk("fl_new_if_aready", if_aready, 1);
        chk("fl_head_if_valid", if_valid, 0);
        next();
        if_flush = 0; if_avalid = 0; mem_data = 32'h11110014;
        #1;
        chk("fl_drop2_if_valid", if_valid, 0);
        chk("fl_drop2_ld_valid", ld_valid, 0);
        next();
        mem_data = 32'h22225000;
        #1;
        chk("fl_ld_valid", ld_valid, 1);
        chk("fl_ld_data", ld_data, 32'h22225000);
        chk("fl_ld_if_valid", if_valid, 0);
        next();
        mem_data = 32'h33330080;
        #1;
        chk("fl_new_if_valid", if_valid, 1);
        chk("fl_new_if_data", if_data, 32'h33330080);
        next();
        mem_valid = 0;
        #1;
        chk("fl_busy", busy, 0);

        // Full: four loads with responses withheld
        ld_avalid = 1; if_avalid = 1; if_addr = 32'h900;
        for (int i = 0; i < 4; i++) begin
            ld_addr = 32'h6000 + 32'(4 * i);
            #1;
            chk($sformatf("full_accept_%0d", i), ld_aready, 1);
            next();
        end
        #1;
        chk("full_mem_avalid", mem_avalid, 0);
        chk("full_readys", {if_aready, ld_aready}, 0);
        next();
        mem_valid = 1; mem_data = 32'h6000;
        #1;
        chk("full_pop_ld_valid", ld_valid, 1);
        chk("full_pop_mem_avalid", mem_avalid, 0);
        next();
        mem_valid = 0;
        #1;
        chk("full_freed_mem_avalid", mem_avalid, 1);
        chk("full_freed_ld_aready", ld_aready, 1);
        next();
        ld_avalid = 0; if_avalid = 0;
        for (int i = 0; i < 4; i++) begin
            mem_valid = 1; mem_data = 32'h7000 + 32'(i);
            #1;
            chk($sformatf("full_drain_%0d", i), ld_valid, 1);
            next();
        end
        mem_valid = 0;
        #1;
        chk("full_drained_busy", busy, 0);

        // Stray response sets sticky err
        next();
        mem_valid = 1; mem_data = 32'hBAD;
        #1;
        chk("err_no_valid", {if_valid, ld_valid}, 0);
        next();
        mem_valid = 0;
        #1;
        chk("err_set", err, 1);
        next();
        #1;
        chk("err_sticky", err, 1);

        // Async reset mid-flight
        if_addr = 32'hC00; if_avalid = 1;
        next();
        if_avalid = 0;
        #1;
        chk("ar_busy_before", busy, 1);
        #2;
        rst = 1;
        #1;
        chk("ar_busy", busy, 0);
        chk("ar_err", err, 0);
        next();
        rst = 0;
        next();
        mem_valid = 1; mem_data = 32'hC00;
        #1;
        chk("ar_stray_if_valid", if_valid, 0);
        next();
        mem_valid = 0;
        #1;
        chk("ar_stray_err", err, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
